// File: rtl/flit_mux_rr.sv
// N:1 wormhole flit mux: round-robin on HEAD flits, lock until TAIL, registered output.
// Optional FLIT_MUX_FORCE_SEL_EN adds force_en/force_sel to pin the IDLE-state grant.
module flit_mux_rr #(
    parameter int NIN   = 4,
    parameter int DATAW = 64,
    parameter int VCHW  = 2,
    parameter int TYPEW = 2
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NIN*(TYPEW+DATAW)-1:0]  idata,
    input  logic [NIN-1:0]                ivalid,
    input  logic [NIN*VCHW-1:0]           ivch,
    output logic [NIN-1:0]                iready,
    output logic [TYPEW+DATAW-1:0]        odata,
    output logic                          ovalid,
    output logic [VCHW-1:0]               ovch,
    input  logic                          oready,
`ifdef FLIT_MUX_FORCE_SEL_EN
    input  logic [$clog2(NIN)-1:0]        force_sel,
    input  logic                          force_en,
`endif
    output logic [$clog2(NIN)-1:0]        owner,
    output logic                          locked
);

    localparam int FW   = TYPEW + DATAW;
    localparam int SELW = $clog2(NIN);

    localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(2);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   owner_q, owner_d;
    logic [SELW-1:0]   rr_q, rr_d, rr_nxt;
    logic [SELW-1:0]   win, sel;
    logic              found;
    logic [NIN-1:0]    pvalid, head, grant;
    logic [FW-1:0]     flit;
    logic [VCHW-1:0]   vch;
    logic [TYPEW-1:0]  ftype;
    logic              can_load, xfer, upd_rr;
    int                idx;

`ifdef FLIT_MUX_FORCE_SEL_EN
    logic forced_q, forced_d;
    assign upd_rr = !forced_q;
`else
    assign upd_rr = 1'b1;
`endif

    assign can_load = !ovalid || oready;

    always_comb begin
        pvalid = '0;
        head   = '0;
        for (int k = 0; k < NIN; k++) begin
            pvalid[k] = ivalid[k] &&
                (idata[k*FW+DATAW +: TYPEW] != T_NONE);
            head[k]   = ivalid[k] &&
                (idata[k*FW+DATAW +: TYPEW] == T_HEAD);
        end
    end

    // First HEAD found scanning upward from rr_q, wrapping at NIN.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
`ifdef FLIT_MUX_FORCE_SEL_EN
        if (force_en) begin
            if (int'(force_sel) < NIN && head[force_sel]) begin
                found = 1'b1;
                win   = force_sel;
            end
        end else begin
`else
        begin
`endif
            for (int i = 0; i < NIN; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= NIN) idx = idx - NIN;
                if (!found && head[idx]) begin
                    found = 1'b1;
                    win   = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (rst_) begin
            if (state_q == IDLE) begin
                if (found) grant[win] = can_load;
            end else begin
                grant[owner_q] = can_load && pvalid[owner_q];
            end
        end
    end

    assign iready = grant;
    assign xfer   = |grant;
    assign sel    = (state_q == IDLE) ? win : owner_q;
    assign flit   = idata[sel*FW +: FW];
    assign vch    = ivch[sel*VCHW +: VCHW];
    assign ftype  = flit[FW-1 -: TYPEW];
    assign rr_nxt = (owner_q == SELW'(NIN-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
`ifdef FLIT_MUX_FORCE_SEL_EN
        forced_d = forced_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d  = LOCKED;
                    owner_d  = win;
`ifdef FLIT_MUX_FORCE_SEL_EN
                    forced_d = force_en;
`endif
                end
            end
            LOCKED: begin
                if (xfer && ftype == T_TAIL) begin
                    state_d = IDLE;
                    if (upd_rr) rr_d = rr_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
`ifdef FLIT_MUX_FORCE_SEL_EN
            forced_q <= 1'b0;
`endif
            odata    <= '0;
            ovch     <= '0;
            ovalid   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
`ifdef FLIT_MUX_FORCE_SEL_EN
            forced_q <= forced_d;
`endif
            if (xfer) begin
                odata  <= flit;
                ovch   <= vch;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end

    assign owner  = owner_q;
    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_flit_mux_rr.sv
// Directed bench for flit_mux_rr: vector table plus long-packet, stall,
// mid-packet reset and (with FLIT_MUX_FORCE_SEL_EN) forced-select sequences.
module tb_flit_mux_rr;

    localparam int NIN   = 4;
    localparam int DATAW = 64;
    localparam int VCHW  = 2;
    localparam int TYPEW = 2;
    localparam int FW    = TYPEW + DATAW;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] T = 2'd2;
    localparam logic [1:0] D = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst_;
    logic [NIN*FW-1:0]    idata;
    logic [NIN-1:0]       ivalid;
    logic [NIN*VCHW-1:0]  ivch;
    logic [NIN-1:0]       iready;
    logic [FW-1:0]        odata;
    logic                 ovalid;
    logic [VCHW-1:0]      ovch;
    logic                 oready;
    logic [1:0]           owner;
    logic                 locked;
`ifdef FLIT_MUX_FORCE_SEL_EN
    logic [1:0]           force_sel;
    logic                 force_en;
`endif

    int checks   = 0;
    int failures = 0;

    flit_mux_rr #(
        .NIN(NIN), .DATAW(DATAW), .VCHW(VCHW), .TYPEW(TYPEW)
    ) dut (
        .clk(clk), .rst_(rst_),
        .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(iready),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .oready(oready),
`ifdef FLIT_MUX_FORCE_SEL_EN
        .force_sel(force_sel), .force_en(force_en),
`endif
        .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [7:0] t;
        logic [3:0] ir;
        logic       ov;
        logic [1:0] ot;
        logic [1:0] os;
        logic       lk;
        logic [1:0] ow;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic v,
                       input logic [1:0] t, input logic [63:0] d);
        ivalid[k] = v;
        idata[k*FW +: FW] = {t, d};
    endtask

    task automatic clr();
        for (int k = 0; k < NIN; k++) put(k, 1'b0, N, 64'd0);
    endtask

    function automatic logic [1:0] ptype(input int j, input int last);
        if (j == 0) return H;
        if (j == last) return T;
        return D;
    endfunction

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] held, f;
    int j, c, out_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[1]  = '{4'b1101, 8'h51, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[2]  = '{4'b1101, 8'h52, 4'b0001, 1'b1, H,    2'd0, 1'b1, 2'd0};
        tbl[3]  = '{4'b1100, 8'h50, 4'b0100, 1'b1, T,    2'd0, 1'b0, 2'd0};
        tbl[4]  = '{4'b1100, 8'h60, 4'b0100, 1'b1, H,    2'd2, 1'b1, 2'd2};
        tbl[5]  = '{4'b1000, 8'h40, 4'b1000, 1'b1, T,    2'd2, 1'b0, 2'd2};
        tbl[6]  = '{4'b1000, 8'h80, 4'b1000, 1'b1, H,    2'd3, 1'b1, 2'd3};
        tbl[7]  = '{4'b0011, 8'h05, 4'b0001, 1'b1, T,    2'd3, 1'b0, 2'd3};
        tbl[8]  = '{4'b0011, 8'h07, 4'b0001, 1'b1, H,    2'd0, 1'b1, 2'd0};
        tbl[9]  = '{4'b0011, 8'h06, 4'b0001, 1'b1, D,    2'd0, 1'b1, 2'd0};
        tbl[10] = '{4'b0011, 8'h07, 4'b0010, 1'b1, T,    2'd0, 1'b0, 2'd0};
        tbl[11] = '{4'b0011, 8'h0B, 4'b0010, 1'b1, H,    2'd1, 1'b1, 2'd1};
        tbl[12] = '{4'b0001, 8'h01, 4'b0001, 1'b1, T,    2'd1, 1'b0, 2'd1};
        tbl[13] = '{4'b0011, 8'h02, 4'b0001, 1'b1, H,    2'd0, 1'b1, 2'd0};
        tbl[14] = '{4'b0110, 8'h30, 4'b0000, 1'b1, T,    2'd0, 1'b0, 2'd0};
        tbl[15] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0};

        rst_   = 1'b0;
        oready = 1'b1;
        ivalid = '0;
        idata  = '0;
        ivch   = {2'd3, 2'd2, 2'd1, 2'd0};
`ifdef FLIT_MUX_FORCE_SEL_EN
        force_en  = 1'b0;
        force_sel = 2'd0;
`endif
        cyc();
        cyc();
        chk("rst_ovalid", ovalid, 0);
        chk("rst_iready", iready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_odata", odata, 0);
        @(negedge clk);
        rst_ = 1'b1;

        // Arbitration table: one row per cycle.
        for (int r = 0; r < 16; r++) begin
            cyc();
            for (int k = 0; k < NIN; k++)
                put(k, tbl[r].v[k], tbl[r].t[2*k +: 2], 64'(k));
            #1;
            chk($sformatf("tbl%0d_iready", r), iready, tbl[r].ir);
            chk($sformatf("tbl%0d_ovalid", r), ovalid, tbl[r].ov);
            chk($sformatf("tbl%0d_locked", r), locked, tbl[r].lk);
            chk($sformatf("tbl%0d_owner", r), owner, tbl[r].ow);
            if (tbl[r].ov) begin
                chk($sformatf("tbl%0d_odata", r), odata,
                    {tbl[r].ot, 62'd0, tbl[r].os});
                chk($sformatf("tbl%0d_ovch", r), ovch, tbl[r].os);
            end
        end
        clr();

        // Port 1: HEAD, 20 DATA, TAIL at full rate.
        for (int i = 0; i < 22; i++) begin
            cyc();
            put(1, 1'b1, ptype(i, 21), 64'h1000 + 64'(i));
            #1;
            chk($sformatf("long%0d_iready", i), iready, 4'b0010);
            chk($sformatf("long%0d_locked", i), locked, i > 0);
            if (i > 0) begin
                chk($sformatf("long%0d_owner", i), owner, 1);
                chk($sformatf("long%0d_odata", i), odata,
                    {ptype(i - 1, 21), 64'h1000 + 64'(i - 1)});
                chk($sformatf("long%0d_ovalid", i), ovalid, 1);
            end
        end
        cyc();
        clr();
        #1;
        chk("long_tail_odata", odata, {T, 64'h1015});
        chk("long_tail_ovch", ovch, 1);
        chk("long_after_locked", locked, 0);
        cyc();
        chk("long_drain_ovalid", ovalid, 0);

        // Port 2 packet with a 5-cycle downstream stall.
        j = 0;
        c = 0;
        out_cnt = 0;
        held = '0;
        exp_q.delete();
        while (out_cnt < 8 && c < 40) begin
            cyc();
            if (j < 8) put(2, 1'b1, ptype(j, 7), 64'h2000 + 64'(j));
            else       put(2, 1'b0, N, 64'd0);
            oready = !(c >= 3 && c < 8);
            #1;
            if (c == 3) held = odata;
            if (c >= 3 && c < 8) begin
                chk($sformatf("stall%0d_iready", c), iready[2], 0);
                chk($sformatf("stall%0d_ovalid", c), ovalid, 1);
                chk($sformatf("stall%0d_odata", c), odata, held);
            end
            if (ovalid && oready) begin
                if (exp_q.size() == 0) begin
                    chk("stall_extra_flit", odata, '1);
                end else begin
                    f = exp_q.pop_front();
                    chk($sformatf("stall_out%0d", out_cnt), odata, f);
                end
                out_cnt++;
            end
            if (ivalid[2] && iready[2]) begin
                exp_q.push_back({ptype(j, 7), 64'h2000 + 64'(j)});
                j++;
            end
            c++;
        end
        chk("stall_out_count", out_cnt, 8);
        chk("stall_in_count", j, 8);
        oready = 1'b1;
        clr();
        cyc();
        cyc();

        // Port 0 packet, reset pulsed while DATA 10 is presented.
        for (int i = 0; i <= 10; i++) begin
            cyc();
            put(0, 1'b1, (i == 0) ? H : D, 64'h3000 + 64'(i));
            #1;
            if (i < 10) chk($sformatf("rp%0d_iready", i), iready, 4'b0001);
        end
        rst_ = 1'b0;
        #1;
        chk("rp_rst_ovalid", ovalid, 0);
        chk("rp_rst_locked", locked, 0);
        chk("rp_rst_owner", owner, 0);
        chk("rp_rst_odata", odata, 0);
        chk("rp_rst_iready", iready, 0);
        rst_ = 1'b1;
        #1;
        chk("rp_held_iready", iready, 4'b0000);
        cyc();
        put(0, 1'b1, D, 64'h300B);
        put(1, 1'b1, H, 64'h4000);
        #1;
        chk("rp_p1_grant", iready, 4'b0010);
        cyc();
        put(0, 1'b1, T, 64'h300C);
        put(1, 1'b1, T, 64'h4001);
        #1;
        chk("rp_p1_tail_iready", iready, 4'b0010);
        chk("rp_p1_owner", owner, 1);
        chk("rp_p1_odata", odata, {H, 64'h4000});
        cyc();
        put(1, 1'b0, N, 64'd0);
        #1;
        chk("rp_p0_still_held", iready, 4'b0000);
        chk("rp_unlocked", locked, 0);
        clr();
        cyc();

`ifdef FLIT_MUX_FORCE_SEL_EN
        // Port 3 packet moves the pointer to 0, then force port 2.
        put(3, 1'b1, H, 64'h5000);
        #1;
        chk("frc_p3_head", iready, 4'b1000);
        cyc();
        put(3, 1'b1, T, 64'h5001);
        cyc();
        put(3, 1'b0, N, 64'd0);
        force_en  = 1'b1;
        force_sel = 2'd1;
        put(0, 1'b1, H, 64'h6000);
        put(2, 1'b1, H, 64'h7000);
        #1;
        chk("frc_nohead_iready", iready, 4'b0000);
        cyc();
        force_sel = 2'd2;
        #1;
        chk("frc_sel2_iready", iready, 4'b0100);
        cyc();
        force_en = 1'b0;
        put(2, 1'b1, T, 64'h7001);
        #1;
        chk("frc_locked_iready", iready, 4'b0100);
        chk("frc_owner", owner, 2);
        cyc();
        put(2, 1'b0, N, 64'd0);
        #1;
        chk("frc_p0_next", iready, 4'b0001);
        cyc();
        put(0, 1'b1, T, 64'h6001);
        #1;
        chk("frc_p0_owner", owner, 0);
        cyc();
        clr();
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
